// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - four-state ALU command sequencer; optional result self-check under ALU_SEQ_CHECK_EN
module alu_op_sequencer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_in_1,
  output logic [31:0]      alu_in_2,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_out_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [7:0]       op_count,
  output logic             chk_err
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [31:0]        alu_in_1_q, alu_in_2_q;
  logic [2:0]         alu_op_q;
  logic [TAG_W-1:0]   tag_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic [7:0]         op_count_q;
  logic               accept, capture, rsp_fire;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid && cmd_ready_q) state_d = EXEC;
      EXEC:    state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready is registered from the next state so it never depends on cmd_valid in the same cycle
  always_comb begin
    accept      = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    capture     = (state_q == CAPT);
    rsp_fire    = (state_q == RESP) && rsp_valid_q && rsp_ready;
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_q <= 1'b0;
      alu_in_1_q  <= '0;
      alu_in_2_q  <= '0;
      alu_op_q    <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      op_count_q  <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      if (accept) begin
        alu_in_1_q <= cmd_a;
        alu_in_2_q <= cmd_b;
        alu_op_q   <= cmd_op;
        tag_q      <= cmd_tag;
      end
      if (capture) begin
        rsp_data_q  <= alu_out_res;
        rsp_tag_q   <= tag_q;
        rsp_valid_q <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid_q <= 1'b0;
        op_count_q  <= op_count_q + 8'd1;
      end
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic chk_err_q;

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a + 32'd1;
      3'b110:  return a - 32'd1;
      default: return b;
    endcase
  endfunction

  // Sticky until reset; the response itself is passed through untouched
  always_ff @(posedge clk) begin
    if (rst)
      chk_err_q <= 1'b0;
    else if (capture && (alu_out_res != alu_model(alu_op_q, alu_in_1_q, alu_in_2_q)))
      chk_err_q <= 1'b1;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign alu_in_1  = alu_in_1_q;
  assign alu_in_2  = alu_in_2_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter TAG_W, default 4, SHALL set the width of the command/response tag.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 cmd_valid  input  1  SHALL indicate a command is offered.
REQ-005 cmd_ready  output  1  SHALL indicate the sequencer accepts a command this cycle.
REQ-006 cmd_op  input  3  SHALL carry the ALU opcode.
REQ-007 cmd_a, cmd_b  input  32 each  SHALL carry operands A and B.
REQ-008 cmd_tag  input  TAG_W  SHALL carry a requester tag that is returned with the result.
REQ-009 alu_in_1, alu_in_2  output  32 each  SHALL drive the ALU operand inputs.
REQ-010 alu_op  output  3  SHALL drive the ALU opcode.
REQ-011 alu_out_res  input  32  SHALL receive the ALU registered result (1-cycle ALU latency).
REQ-012 rsp_valid  output  1; rsp_ready  input  1  SHALL form the response handshake.
REQ-013 rsp_data  output  32; rsp_tag  output  TAG_W  SHALL carry the result and its echoed tag.
REQ-014 op_count  output  8  SHALL count completed responses.
REQ-015 chk_err  output  1  SHALL flag a self-check mismatch (see Configuration).

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, EXEC, CAPT, RESP.
REQ-017 cmd_ready SHALL be 1 only in IDLE, registered and not combinationally dependent on cmd_valid.
REQ-018 The transfer cmd_valid&&cmd_ready at edge E0 SHALL do all of the following: register cmd_op, cmd_a, cmd_b onto alu_op, alu_in_1, alu_in_2; latch cmd_tag; move the FSM to EXEC.
REQ-019 EXEC SHALL last one cycle, with alu_* held stable so the ALU samples them at edge E1; the FSM then moves to CAPT.
REQ-020 In CAPT, at edge E2, the block SHALL latch alu_out_res into rsp_data, set rsp_tag, assert rsp_valid and move to RESP.
REQ-021 alu_in_1, alu_in_2 and alu_op SHALL hold their values from the accepting edge until the next accepted command.
REQ-022 In RESP, rsp_valid, rsp_data and rsp_tag SHALL remain stable while rsp_ready=0, for an unbounded number of cycles.
REQ-023 When rsp_valid&&rsp_ready at an edge, the block SHALL do all of the following: deassert rsp_valid; increment op_count modulo 256 (255 wraps to 0); return to IDLE.
REQ-024 A command held on cmd_valid outside IDLE SHALL NOT be accepted or corrupted; it is accepted in the first IDLE cycle.
REQ-025 Throughput SHALL be at most one command per 4 cycles (IDLE, EXEC, CAPT, RESP with rsp_ready=1).
REQ-026 cmd_* values SHALL be ignored when cmd_valid=0; rsp_ready SHALL be ignored outside RESP.

Reset
REQ-027 With rst=1 at an edge, the block SHALL set FSM=IDLE, cmd_ready=0, alu_in_1=alu_in_2=0, alu_op=0, rsp_valid=0, rsp_data=0, rsp_tag=0, op_count=0, chk_err=0.
REQ-028 cmd_ready SHALL rise in the first cycle after rst deasserts.
REQ-029 A reset in EXEC, CAPT or RESP SHALL discard the in-flight command with no response and no op_count increment.

Configuration
REQ-030 Macro ALU_SEQ_CHECK_EN defined: in CAPT, the block SHALL compare alu_out_res with an internal model computed from the latched op/A/B, modulo 2^32. Model: 000 A; 001 A+B; 010 A-B; 011 A&B; 100 A|B; 101 A+1; 110 A-1; 111 B.
REQ-031 With ALU_SEQ_CHECK_EN defined, a mismatch SHALL set chk_err=1, sticky until rst; the response is still delivered unchanged.
REQ-032 Macro ALU_SEQ_CHECK_EN undefined: the model logic SHALL be absent and chk_err SHALL be tied to 0.

Verification
REQ-033 After rst, cmd op=001 A=5 B=7 tag=3, with rsp_ready=1 -> rsp_valid rises exactly two edges after acceptance, rsp_data=12, rsp_tag=3, op_count=1.
REQ-034 op=010 A=0 B=1 -> rsp_data=0xFFFFFFFF; op=101 A=0xFFFFFFFF -> rsp_data=0x00000000.
REQ-035 rsp_ready=0 for 5 cycles with a second cmd_valid held -> rsp_* stable, cmd_ready=0 throughout; the second command is accepted in the cycle after the handshake returns the FSM to IDLE.
REQ-036 rst pulsed during EXEC of op=011 A=0xF0 B=0x3C -> no rsp_valid, op_count=0, cmd_ready=1 one cycle after rst falls.
REQ-037 With ALU_SEQ_CHECK_EN and a faulty ALU stub returning 0, op=001 A=1 B=1 -> rsp_data=0, chk_err=1 and still 1 after 3 further good ops; without the macro chk_err=0.
REQ-038 256 consecutive completed ops -> op_count=0 after the 256th handshake.
